// File: rtl/multi_ch_serializer.sv
// N-lane parallel-to-serial converter running on the bit clock, emitting 1 (SDR) or 2 (DDR) bits per lane per cycle.
// Words are fetched by ready/valid once per word period. Training and idle words are also supported, and underrun is sticky.
module multi_ch_serializer #(
  parameter int NCH       = 4,
  parameter int WIDTH     = 10,
  parameter int DDR       = 1,
  parameter int MSB_FIRST = 0,
  parameter logic [WIDTH-1:0] TRAIN_PAT = 10'b1111100000,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic                                train,
  input  logic                                in_valid,
  input  logic [NCH*WIDTH-1:0]                in_data,
  output logic                                in_ready,
  output logic [NCH*((DDR != 0) ? 2 : 1)-1:0] ser_out,
  output logic                                word_start,
  output logic                                underrun,
  input  logic                                clr_underrun
);

  localparam int BPC = (DDR != 0) ? 2 : 1;
  localparam int PH  = WIDTH / BPC;
  localparam int PW  = (PH > 1) ? $clog2(PH) : 1;
  localparam logic [PW-1:0] LAST = PW'(PH - 1);

  typedef enum logic [1:0] {
    SRC_DATA,
    SRC_TRAIN,
    SRC_IDLE
  } src_e;

  logic [PW-1:0]    phase;
  logic [WIDTH-1:0] sr        [NCH];
  logic [WIDTH-1:0] next_word [NCH];
  logic             at_last;
  logic             load;
  src_e             src;

  // MSB-first lanes are reversed once at load so the shift path is shared.
  function automatic logic [WIDTH-1:0] orient(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = w;
    if (MSB_FIRST != 0) begin
      for (int unsigned i = 0; i < WIDTH; i++) r[i] = w[WIDTH-1-i];
    end
    return r;
  endfunction

  assign at_last  = (phase == LAST);
  assign load     = en & at_last;
  assign in_ready = en & ~train & at_last;

  always_comb begin
    if (train)         src = SRC_TRAIN;
    else if (in_valid) src = SRC_DATA;
    else               src = SRC_IDLE;
  end

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      case (src)
        SRC_TRAIN: next_word[c] = TRAIN_PAT;
        SRC_DATA:  next_word[c] = in_data[c*WIDTH +: WIDTH];
        default:   next_word[c] = IDLE_WORD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= LAST;
      word_start <= 1'b0;
      underrun   <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) sr[c] <= '0;
    end else begin
      if (load && (src == SRC_IDLE)) underrun <= 1'b1;
      else if (clr_underrun)         underrun <= 1'b0;

      if (!en) begin
        phase      <= LAST;
        word_start <= 1'b0;
        for (int unsigned c = 0; c < NCH; c++) sr[c] <= '0;
      end else if (at_last) begin
        phase      <= '0;
        word_start <= 1'b1;
        for (int unsigned c = 0; c < NCH; c++) sr[c] <= orient(next_word[c]);
      end else begin
        phase      <= phase + 1'b1;
        word_start <= 1'b0;
        for (int unsigned c = 0; c < NCH; c++) sr[c] <= sr[c] >> BPC;
      end
    end
  end

  always_comb begin
    ser_out = '0;
    for (int unsigned c = 0; c < NCH; c++) ser_out[c*BPC +: BPC] = sr[c][BPC-1:0];
  end

endmodule

// File: tb/tb_multi_ch_serializer.sv
// Bench for multi_ch_serializer: three configurations share one stimulus and are checked every cycle against a word/position model.
module tb_multi_ch_serializer;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst_n, en, train, in_valid, clr;
  logic [4*W-1:0] in_data;

  logic a_ready, a_ws, a_ur; logic [7:0] a_ser;
  logic b_ready, b_ws, b_ur; logic [0:0] b_ser;
  logic c_ready, c_ws, c_ur; logic [3:0] c_ser;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_ch_serializer #(.NCH(4), .WIDTH(W), .DDR(1), .MSB_FIRST(0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .train(train), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_ready), .ser_out(a_ser), .word_start(a_ws), .underrun(a_ur), .clr_underrun(clr));
  multi_ch_serializer #(.NCH(1), .WIDTH(W), .DDR(0), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .train(train), .in_valid(in_valid), .in_data(in_data[W-1:0]),
    .in_ready(b_ready), .ser_out(b_ser), .word_start(b_ws), .underrun(b_ur), .clr_underrun(clr));
  multi_ch_serializer #(.NCH(4), .WIDTH(W), .DDR(0), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .train(train), .in_valid(in_valid), .in_data(in_data),
    .in_ready(c_ready), .ser_out(c_ser), .word_start(c_ws), .underrun(c_ur), .clr_underrun(clr));

  // Model: each instance holds its current word per lane and which chunk of it is on the wire.
  int          m_bpc [3] = '{2, 1, 1};
  int          m_nch [3] = '{4, 1, 4};
  bit          m_msb [3] = '{1'b0, 1'b0, 1'b1};
  bit          m_busy[3];
  int          m_pos [3];
  bit          m_ws  [3];
  bit          m_ur  [3];
  logic [W-1:0] m_w  [3][4];

  function automatic bit m_boundary(int i);
    return !m_busy[i] || (m_pos[i] == W / m_bpc[i] - 1);
  endfunction

  function automatic logic [7:0] exp_ser(int i);
    logic [7:0] r;
    int idx;
    r = '0;
    if (m_busy[i]) begin
      for (int c = 0; c < m_nch[i]; c++) begin
        for (int b = 0; b < m_bpc[i]; b++) begin
          idx = m_pos[i] * m_bpc[i] + b;
          r[c*m_bpc[i] + b] = m_msb[i] ? m_w[i][c][W-1-idx] : m_w[i][c][idx];
        end
      end
    end
    return r;
  endfunction

  function automatic bit exp_ready(int i);
    return en && !train && m_boundary(i);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i] <= 1'b0; m_pos[i] <= 0; m_ws[i] <= 1'b0; m_ur[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (en && m_boundary(i) && !train && !in_valid) m_ur[i] <= 1'b1;
        else if (clr)                                   m_ur[i] <= 1'b0;
        if (!en) begin
          m_busy[i] <= 1'b0; m_ws[i] <= 1'b0;
        end else if (m_boundary(i)) begin
          m_busy[i] <= 1'b1; m_pos[i] <= 0; m_ws[i] <= 1'b1;
          for (int c = 0; c < 4; c++)
            m_w[i][c] <= train ? 10'b1111100000 : (in_valid ? in_data[c*W +: W] : 10'b0);
        end else begin
          m_pos[i] <= m_pos[i] + 1; m_ws[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a.ser_out", a_ser, exp_ser(0));
    chk("b.ser_out", {7'b0, b_ser}, exp_ser(1));
    chk("c.ser_out", {4'b0, c_ser}, exp_ser(2));
    chk("a.in_ready", a_ready, exp_ready(0));
    chk("b.in_ready", b_ready, exp_ready(1));
    chk("c.in_ready", c_ready, exp_ready(2));
    chk("a.word_start", a_ws, m_ws[0]);
    chk("b.word_start", b_ws, m_ws[1]);
    chk("c.word_start", c_ws, m_ws[2]);
    chk("a.underrun", a_ur, m_ur[0]);
    chk("b.underrun", b_ur, m_ur[1]);
    chk("c.underrun", c_ur, m_ur[2]);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [W-1:0] got_b, got_c, got_t;
  int cnt;
  bit found;

  initial begin
    rst_n = 1'b0; en = 1'b0; train = 1'b0; in_valid = 1'b0; clr = 1'b0;
    in_data = {10'h00F, 10'h3C0, 10'h155, 10'h2AB};
    repeat (2) step();
    chk("reset.ser", {a_ser, b_ser, c_ser}, 32'h0);
    chk("reset.flags", {a_ready, a_ws, a_ur, b_ur, c_ur}, 32'h0);
    rst_n = 1'b1;
    step();
    en = 1'b1; in_valid = 1'b1;
    #1 chk("first.ready", {a_ready, b_ready, c_ready}, 32'h7);
    step();
    // First chunk after accept: A pairs {b1,b0} per lane, B bit 0, C bit 9 per lane.
    chk("first.a_ser", a_ser, 32'hC7);
    chk("first.b_ser", b_ser, 32'h1);
    chk("first.c_ser", c_ser, 32'h5);
    chk("first.ws", {a_ws, b_ws, c_ws}, 32'h7);
    for (int k = 0; k < W; k++) begin
      got_b[k] = b_ser[0];
      got_c[W-1-k] = c_ser[0];
      step();
    end
    chk("sdr.lsb_word", got_b, 32'h2AB);
    chk("msb.lane0_word", got_c, 32'h2AB);

    in_data = {10'h1A5, 10'h0F0, 10'h333, 10'h2C8};
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (a_ready) cnt++;
      step();
    end
    chk("ddr.ready_count15", cnt, 3);

    in_valid = 1'b0;
    repeat (12) step();
    chk("underrun.set", {a_ur, b_ur, c_ur}, 32'h7);
    in_valid = 1'b1;
    repeat (3) step();
    chk("underrun.sticky", a_ur, 32'h1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (a_ready) found = 1'b1; else step();
    end
    chk("wait.a_ready", found, 32'h1);
    in_valid = 1'b0; clr = 1'b1;
    step();
    chk("underrun.set_wins", a_ur, 32'h1);
    in_valid = 1'b1;
    step();
    chk("underrun.cleared", a_ur, 32'h0);
    clr = 1'b0;

    repeat (2) step();
    train = 1'b1;
    #1 chk("train.ready_low", a_ready, 32'h0);
    repeat (12) step();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (a_ws) found = 1'b1; else step();
    end
    chk("wait.a_word_start", found, 32'h1);
    for (int k = 0; k < 5; k++) begin
      got_t[2*k]   = a_ser[0];
      got_t[2*k+1] = a_ser[1];
      step();
    end
    chk("train.pattern", got_t, 32'h3E0);
    train = 1'b0;

    repeat (8) step();
    en = 1'b0;
    step();
    chk("en_off.ser", {a_ser, b_ser, c_ser}, 32'h0);
    repeat (3) step();
    en = 1'b1;
    #1 chk("en_on.ready", {a_ready, b_ready, c_ready}, 32'h7);
    step();
    chk("en_on.ws", {a_ws, b_ws, c_ws}, 32'h7);

    repeat (7) step();
    #2 rst_n = 1'b0;
    #1 chk("async_reset.ser", {a_ser, b_ser, c_ser}, 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (14) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
